// File: rtl/hbp_pkg.sv
// rtl/hbp_pkg.sv - shared counter helpers for the hybrid branch predictor
package hbp_pkg;

    localparam int CTR_MAX_W = 8;

    typedef logic [CTR_MAX_W-1:0] ctr_t;

    // Weakly not-taken / weakly local: one below the taken threshold.
    function automatic ctr_t ctr_weak(input int bits);
        return ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t v, input int bits);
        ctr_t max_v;
        max_v = ctr_t'((1 << bits) - 1);
        return (v == max_v) ? v : v + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t v);
        return (v == '0) ? v : v - ctr_t'(1);
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// rtl/sat_counter_table.sv - saturating counter array, combinational read, synchronous train
module sat_counter_table
    import hbp_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int CTR_BITS = 2,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic                wr_up
);

    localparam logic [CTR_BITS-1:0] RST_VAL = CTR_BITS'(ctr_weak(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q [DEPTH];
    logic [CTR_BITS-1:0] ctr_d [DEPTH];

    assign rd_ctr = ctr_q[rd_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) begin
            ctr_d[wr_idx] = wr_up ? CTR_BITS'(sat_inc(ctr_t'(ctr_q[wr_idx]), CTR_BITS))
                                  : CTR_BITS'(sat_dec(ctr_t'(ctr_q[wr_idx])));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= RST_VAL;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/hybrid_branch_predictor.sv
// rtl/hybrid_branch_predictor.sv - BTB + bimodal/gshare tournament predictor; HBP_RAS_EN adds a return stack
module hybrid_branch_predictor
    import hbp_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int BTB_ENTRIES     = 64,
    parameter int LOCAL_ENTRIES   = 64,
    parameter int GHR_BITS        = 8,
    parameter int CHOOSER_ENTRIES = 64,
    parameter int CTR_BITS        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [XLEN-1:0]       pred_target,
    output logic [GHR_BITS+1:0]   pred_meta,
    input  logic                  upd_valid,
    input  logic [XLEN-1:0]       upd_pc,
    input  logic                  upd_is_br,
    input  logic                  upd_is_jal,
`ifdef HBP_RAS_EN
    input  logic                  upd_is_call,
    input  logic                  upd_is_ret,
`endif
    input  logic                  upd_taken,
    input  logic [XLEN-1:0]       upd_target,
    input  logic [GHR_BITS+1:0]   upd_meta,
    output logic [GHR_BITS-1:0]   ghr_out
);

    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W     = XLEN - BTB_IDX_W - 2;
    localparam int LOC_IDX_W = $clog2(LOCAL_ENTRIES);
    localparam int CH_IDX_W  = $clog2(CHOOSER_ENTRIES);

    logic                 btb_valid_q  [BTB_ENTRIES];
    logic                 btb_valid_d  [BTB_ENTRIES];
    logic [TAG_W-1:0]     btb_tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]     btb_tag_d    [BTB_ENTRIES];
    logic [XLEN-1:0]      btb_target_q [BTB_ENTRIES];
    logic [XLEN-1:0]      btb_target_d [BTB_ENTRIES];
    logic                 btb_jal_q    [BTB_ENTRIES];
    logic                 btb_jal_d    [BTB_ENTRIES];
    logic [GHR_BITS-1:0]  ghr_q, ghr_d;

    logic [BTB_IDX_W-1:0] rd_idx, wr_idx;
    logic [CTR_BITS-1:0]  local_ctr, global_ctr, chooser_ctr;
    logic                 local_pred, global_pred, dir_pred;
    logic                 train_br, alloc;
    logic [GHR_BITS-1:0]  upd_ghr;
    logic                 upd_lp, upd_gp;
    logic                 unused_bits;

    assign rd_idx      = if_pc[BTB_IDX_W+1:2];
    assign wr_idx      = upd_pc[BTB_IDX_W+1:2];
    assign upd_ghr     = upd_meta[GHR_BITS+1:2];
    assign upd_lp      = upd_meta[1];
    assign upd_gp      = upd_meta[0];
    assign train_br    = upd_valid & upd_is_br;
    assign ghr_out     = ghr_q;
    assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};

`ifdef HBP_RAS_EN
    logic                 btb_ret_q [BTB_ENTRIES];
    logic                 btb_ret_d [BTB_ENTRIES];
    logic [XLEN-1:0]      ras_q [4];
    logic [XLEN-1:0]      ras_d [4];
    logic [1:0]           ras_sp_q, ras_sp_d;
    logic [2:0]           ras_cnt_q, ras_cnt_d;
    logic [XLEN-1:0]      ras_top;

    assign ras_top = (ras_cnt_q != 3'd0) ? ras_q[ras_sp_q] : '0;
    assign alloc   = upd_valid & upd_taken & (upd_is_br | upd_is_jal | upd_is_call | upd_is_ret);

    // Pop first so a simultaneous call+return replaces the top entry.
    always_comb begin
        ras_d     = ras_q;
        ras_sp_d  = ras_sp_q;
        ras_cnt_d = ras_cnt_q;
        if (upd_valid && upd_is_ret && ras_cnt_q != 3'd0) begin
            ras_sp_d  = ras_sp_q - 2'd1;
            ras_cnt_d = ras_cnt_q - 3'd1;
        end
        if (upd_valid && upd_is_call) begin
            ras_sp_d         = ras_sp_d + 2'd1;
            ras_d[ras_sp_d]  = upd_pc + XLEN'(4);
            ras_cnt_d        = (ras_cnt_d == 3'd4) ? 3'd4 : ras_cnt_d + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                ras_q[i] <= '0;
            end
            ras_sp_q  <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_q     <= ras_d;
            ras_sp_q  <= ras_sp_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end
`else
    assign alloc = upd_valid & upd_taken & (upd_is_br | upd_is_jal);
`endif

    always_comb begin
        local_pred  = local_ctr[CTR_BITS-1];
        global_pred = global_ctr[CTR_BITS-1];
        dir_pred    = chooser_ctr[CTR_BITS-1] ? global_pred : local_pred;
        pred_hit    = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == if_pc[XLEN-1:BTB_IDX_W+2]);
        pred_taken  = pred_hit & (btb_jal_q[rd_idx] | dir_pred);
        pred_target = pred_hit ? btb_target_q[rd_idx] : '0;
`ifdef HBP_RAS_EN
        if (pred_hit && btb_ret_q[rd_idx]) begin
            pred_taken  = 1'b1;
            pred_target = ras_top;
        end
`endif
        pred_meta   = {ghr_q, local_pred, global_pred};
    end

    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        btb_jal_d    = btb_jal_q;
`ifdef HBP_RAS_EN
        btb_ret_d    = btb_ret_q;
`endif
        ghr_d        = train_br ? {ghr_q[GHR_BITS-2:0], upd_taken} : ghr_q;
        if (alloc) begin
            btb_valid_d[wr_idx]  = 1'b1;
            btb_tag_d[wr_idx]    = upd_pc[XLEN-1:BTB_IDX_W+2];
            btb_target_d[wr_idx] = upd_target;
`ifdef HBP_RAS_EN
            btb_jal_d[wr_idx]    = upd_is_jal | upd_is_call;
            btb_ret_d[wr_idx]    = upd_is_ret;
`else
            btb_jal_d[wr_idx]    = upd_is_jal;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_jal_q[i]    <= 1'b0;
`ifdef HBP_RAS_EN
                btb_ret_q[i]    <= 1'b0;
`endif
            end
            ghr_q <= '0;
        end else begin
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
            btb_jal_q    <= btb_jal_d;
`ifdef HBP_RAS_EN
            btb_ret_q    <= btb_ret_d;
`endif
            ghr_q        <= ghr_d;
        end
    end

    sat_counter_table #(.DEPTH(LOCAL_ENTRIES), .CTR_BITS(CTR_BITS)) u_local (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (if_pc[LOC_IDX_W+1:2]),
        .rd_ctr (local_ctr),
        .wr_en  (train_br),
        .wr_idx (upd_pc[LOC_IDX_W+1:2]),
        .wr_up  (upd_taken)
    );

    // Gshare trains at the index formed with the history seen at fetch.
    sat_counter_table #(.DEPTH(1 << GHR_BITS), .CTR_BITS(CTR_BITS)) u_gshare (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (if_pc[GHR_BITS+1:2] ^ ghr_q),
        .rd_ctr (global_ctr),
        .wr_en  (train_br),
        .wr_idx (upd_pc[GHR_BITS+1:2] ^ upd_ghr),
        .wr_up  (upd_taken)
    );

    sat_counter_table #(.DEPTH(CHOOSER_ENTRIES), .CTR_BITS(CTR_BITS)) u_chooser (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (if_pc[CH_IDX_W+1:2]),
        .rd_ctr (chooser_ctr),
        .wr_en  (train_br & (upd_lp != upd_gp)),
        .wr_idx (upd_pc[CH_IDX_W+1:2]),
        .wr_up  (upd_gp == upd_taken)
    );

endmodule
